// File: rtl/mips_pkg.sv
// Shared widths and the writeback request type for the MIPS register-file write path.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/mips_wb_slot.sv
// One-entry writeback holding slot: accepts a request while empty or while draining.
module mips_wb_slot
  import mips_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ADDR_W_P-1:0] in_reg,
  input  logic [DATA_W_P-1:0] in_data,
  input  logic                grant,
  output logic                ready,
  output logic                load,
  output logic                full,
  output logic [ADDR_W_P-1:0] slot_reg,
  output logic [DATA_W_P-1:0] slot_data
);

  logic                full_q, full_d;
  logic [ADDR_W_P-1:0] reg_q, reg_d;
  logic [DATA_W_P-1:0] data_q, data_d;

  // A slot being granted this cycle frees up on the same edge, so it may reload.
  assign ready = !full_q || grant;
  assign load  = in_valid && ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full_d = full_q;
    reg_d  = reg_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      reg_d  = in_reg;
      data_d = in_data;
    end else if (grant) begin
      full_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign full      = full_q;
  assign slot_reg  = reg_q;
  assign slot_data = data_q;

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// Oldest-first arbiter sharing the register-file write port between ALU (A) and load (B) writeback.
module mips_regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W_P-1:0]      a_reg,
  input  logic [DATA_W_P-1:0]      a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W_P-1:0]      b_reg,
  input  logic [DATA_W_P-1:0]      b_data,
  output logic [ADDR_W_P-1:0]      write_reg,
  output logic [DATA_W_P-1:0]      write_data,
  output logic                     signal_reg_write,
  output logic [2**ADDR_W_P-1:0]   pending_regs,
  output logic                     busy
);

  localparam int NREGS = 2 ** ADDR_W_P;

  logic                grant_a, grant_b;
  logic                load_a, load_b;
  logic                full_a, full_b;
  logic [ADDR_W_P-1:0] slot_a_reg, slot_b_reg;
  logic [DATA_W_P-1:0] slot_a_data, slot_b_data;

  logic                a_older_q, a_older_d;
  logic [ADDR_W_P-1:0] write_reg_q, write_reg_d;
  logic [DATA_W_P-1:0] write_data_q, write_data_d;
  logic                we_q, we_d;

  mips_wb_slot #(.DATA_W_P(DATA_W_P), .ADDR_W_P(ADDR_W_P)) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid),
    .in_reg    (a_reg),
    .in_data   (a_data),
    .grant     (grant_a),
    .ready     (a_ready),
    .load      (load_a),
    .full      (full_a),
    .slot_reg  (slot_a_reg),
    .slot_data (slot_a_data)
  );

  mips_wb_slot #(.DATA_W_P(DATA_W_P), .ADDR_W_P(ADDR_W_P)) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_valid),
    .in_reg    (b_reg),
    .in_data   (b_data),
    .grant     (grant_b),
    .ready     (b_ready),
    .load      (load_b),
    .full      (full_b),
    .slot_reg  (slot_b_reg),
    .slot_data (slot_b_data)
  );

  // Grant depends only on slot state, keeping ready free of any path from valid.
  assign grant_a = full_a && (!full_b || a_older_q);
  assign grant_b = full_b && !grant_a;

  always_comb begin
    a_older_d    = a_older_q;
    we_d         = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    // The slot that stays full across a single-slot load becomes the older one.
    if (load_a && load_b) begin
      a_older_d = 1'b1;
    end else if (load_a && full_b && !grant_b) begin
      a_older_d = 1'b0;
    end else if (load_b && full_a && !grant_a) begin
      a_older_d = 1'b1;
    end

    if (grant_a) begin
      write_reg_d  = slot_a_reg;
      write_data_d = slot_a_data;
      we_d         = (slot_a_reg != '0);
    end else if (grant_b) begin
      write_reg_d  = slot_b_reg;
      write_data_d = slot_b_data;
      we_d         = (slot_b_reg != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_older_q    <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      we_q         <= 1'b0;
    end else begin
      a_older_q    <= a_older_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      we_q         <= we_d;
    end
  end

  // Register 0 is hardwired, so its pending bit is never raised.
  always_comb begin
    pending_regs = '0;
    for (int r = 1; r < NREGS; r++) begin
      pending_regs[r] = (full_a && (slot_a_reg == ADDR_W_P'(r))) ||
                        (full_b && (slot_b_reg == ADDR_W_P'(r))) ||
                        (we_q   && (write_reg_q == ADDR_W_P'(r)));
    end
  end

  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign signal_reg_write = we_q;
  assign busy             = full_a || full_b || we_q;

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Scoreboard bench for mips_regfile_write_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_mips_regfile_write_arbiter;
  import mips_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                a_valid, b_valid;
  logic                a_ready, b_ready;
  logic [ADDR_W-1:0]   a_reg, b_reg;
  logic [DATA_W-1:0]   a_data, b_data;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   write_data;
  logic                signal_reg_write;
  logic [NUM_REGS-1:0] pending_regs;
  logic                busy;

  int checks   = 0;
  int failures = 0;
  int issue_count = 0;
  wb_req_t exp_q[$];
  logic [DATA_W-1:0] rf_model [NUM_REGS];

  always #5 clk = ~clk;

  mips_regfile_write_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_reg            (a_reg),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_reg            (b_reg),
    .b_data           (b_data),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .pending_regs     (pending_regs),
    .busy             (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    wb_req_t e;
    e.dst  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write_reg"},  64'(write_reg), 64'd0);
    check({tag, "_write_data"}, 64'(write_data), 64'd0);
    check({tag, "_we"},         64'(signal_reg_write), 64'd0);
    check({tag, "_pending"},    64'(pending_regs), 64'd0);
    check({tag, "_busy"},       64'(busy), 64'd0);
    check({tag, "_a_ready"},    64'(a_ready), 64'd1);
    check({tag, "_b_ready"},    64'(b_ready), 64'd1);
  endtask

  // Monitor: every enabled write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && signal_reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got reg %0d data 0x%0h with nothing expected at %0t",
                 write_reg, write_data, $time);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("wb_reg",  64'(write_reg),  64'(e.dst));
        check("wb_data", 64'(write_data), 64'(e.data));
      end
      rf_model[write_reg] = write_data;
      issue_count++;
    end
  end

  initial begin
    int ia, ib, base_issues;
    logic acc_a, acc_b;

    for (int i = 0; i < NUM_REGS; i++) rf_model[i] = '0;
    rst_n   = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg   = '0;   b_reg   = '0;
    a_data  = '0;   b_data  = '0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single uncontended write: reg 2.
    a_valid = 1'b1; a_reg = 5'd2; a_data = 32'hE001_C000;
    push(5'd2, 32'hE001_C000);
    check("t1_a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check("t1_pending_queued", 64'(pending_regs), 64'h4);
    check("t1_we_not_yet", 64'(signal_reg_write), 64'd0);
    tick();
    check("t1_we_high", 64'(signal_reg_write), 64'd1);
    check("t1_write_reg", 64'(write_reg), 64'd2);
    check("t1_pending_issuing", 64'(pending_regs), 64'h4);
    tick();
    check("t1_we_low", 64'(signal_reg_write), 64'd0);
    check("t1_pending_clear", 64'(pending_regs), 64'd0);
    check("t1_busy_clear", 64'(busy), 64'd0);
    check("t1_write_reg_hold", 64'(write_reg), 64'd2);
    check("t1_write_data_hold", 64'(write_data), 64'hE001_C000);

    // Simultaneous accept: A wins the tie.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
    push(5'd3, 32'h11);
    push(5'd4, 32'h22);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t2_a_ready", 64'(a_ready), 64'd1);
    check("t2_b_ready_stall", 64'(b_ready), 64'd0);
    check("t2_pending", 64'(pending_regs), 64'h18);
    tick();
    check("t2_first_is_a", 64'(write_reg), 64'd3);
    check("t2_b_ready_after", 64'(b_ready), 64'd1);
    tick();
    check("t2_second_is_b", 64'(write_reg), 64'd4);
    tick();

    // Same destination: B loads first, A follows while B is still full.
    b_valid = 1'b1; b_reg = 5'd5; b_data = 32'hAA;
    push(5'd5, 32'hAA);
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hBB;
    push(5'd5, 32'hBB);
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t3_readback_reg5", 64'(rf_model[5]), 64'hBB);

    // Register 0: handshake completes but no enable and no pending bit.
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF_FFFF;
    check("t4_a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check("t4_pending_queued", 64'(pending_regs), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    tick();
    check("t4_we_suppressed", 64'(signal_reg_write), 64'd0);
    check("t4_pending_issue", 64'(pending_regs), 64'd0);
    check("t4_write_data", 64'(write_data), 64'hFFFF_FFFF);
    tick();

    // Streaming: ten beats per requester, issued alternately A, B, A, B ...
    for (int k = 0; k < 10; k++) begin
      push(5'(10 + k), 32'hA000_0000 + 32'(k));
      push(5'(20 + k), 32'hB000_0000 + 32'(k));
    end
    base_issues = issue_count;
    ia = 0; ib = 0;
    for (int cyc = 0; cyc < 60 && (ia < 10 || ib < 10); cyc++) begin
      a_valid = (ia < 10); a_reg = 5'(10 + ia); a_data = 32'hA000_0000 + 32'(ia);
      b_valid = (ib < 10); b_reg = 5'(20 + ib); b_data = 32'hB000_0000 + 32'(ib);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) tick();
    check("t5_a_accepts", 64'(ia), 64'd10);
    check("t5_b_accepts", 64'(ib), 64'd10);
    check("t5_issue_total", 64'(issue_count - base_issues), 64'd20);
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // Async reset with both slots full and a write issuing.
    a_valid = 1'b1; a_reg = 5'd9;  a_data = 32'h1;
    b_valid = 1'b1; b_reg = 5'd10; b_data = 32'h2;
    push(5'd9, 32'h1);
    tick();
    b_valid = 1'b0;
    a_reg = 5'd11; a_data = 32'h3;
    check("t6_a_reload_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t6_we_before_reset", 64'(signal_reg_write), 64'd1);
    check("t6_pending_before_reset", 64'(pending_regs), 64'h0E00);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    rst_n = 1'b1;
    tick();
    a_valid = 1'b1; a_reg = 5'd12; a_data = 32'h1234;
    push(5'd12, 32'h1234);
    tick();
    a_valid = 1'b0;
    tick();
    check("t6_post_reset_we", 64'(signal_reg_write), 64'd1);
    check("t6_post_reset_reg", 64'(write_reg), 64'd12);
    tick();
    tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_regfile_write_arbiter.md
# mips_regfile_write_arbiter

Shares the single write port of the MIPS register file between two writeback requesters (A: ALU result path, B: load/memory result path). Each requester owns a one-entry holding slot with a valid/ready handshake. An oldest-first arbiter drains the slots into registered write_reg / write_data / signal_reg_write outputs that connect directly to the register file. A pending-register mask is exported for hazard detection on the read side.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, register index width (2**ADDR_W registers)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- a_valid  in  1  requester A offers a write
- a_ready  out  1  A slot can accept this cycle
- a_reg  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid, b_ready, b_reg, b_data  same as A, for requester B
- write_reg  out  ADDR_W  to register file write_reg
- write_data  out  DATA_W  to register file write_data
- signal_reg_write  out  1  to register file write enable
- pending_regs  out  2**ADDR_W  bit r set while a write to r is queued or issuing
- busy  out  1  any slot full or signal_reg_write high

## Operation
- Slot X (X = A, B): fields full, reg, data, plus one shared age bit (a_older).
- Accept: x_valid && x_ready at edge → slot loaded, full=1. x_ready = !full_x || grant_x (a slot draining this cycle can reload on the same edge).
- Grant (combinational, from slot state): only one full → grant it. Both full → grant the older; if loaded on the same edge, grant A.
- Age: on any edge where exactly one slot is loaded while the other remains full, the remaining one becomes older. a_older is meaningful only while both slots are full.
- Issue: on the grant edge, write_reg ← slot.reg, write_data ← slot.data, signal_reg_write ← (slot.reg != 0). Granted slot clears unless reloaded on the same edge.
- No grant → signal_reg_write ← 0; write_reg and write_data hold their previous values.
- Register 0: the write is accepted and granted normally, but the enable is suppressed and the register 0 bit of pending_regs is never set.
- Same destination in both slots: issued strictly oldest-first, so the later write lands last.
- pending_regs: OR of (full_A ? onehot(a_reg)), (full_B ? onehot(b_reg)), and (signal_reg_write ? onehot(write_reg)), with bit 0 masked.
- No data path modification. Widths are passed through unchanged.

## Timing
- Reset (async assert, sync release): slots empty, a_older=0, write_reg=0, write_data=0, signal_reg_write=0, pending_regs=0, busy=0, a_ready=b_ready=1.
- Latency: accept at edge N → signal_reg_write high during cycle N+1..N+2 → register file writes at edge N+2. Minimum two edges from handshake to register update.
- Throughput: one write per cycle sustained. With both requesters streaming, each sees ready on alternate cycles.
- Simultaneous accept on both slots plus drain: allowed. At most one grant per edge.
- Reset mid-operation: queued and issuing writes are discarded and signal_reg_write drops immediately. Requesters must re-offer.
- Requesters hold reg/data stable while valid && !ready.

## Structure
- Package mips_pkg: DATA_W and ADDR_W defaults, NUM_REGS = 2**ADDR_W, and a wb_req struct {reg, data}.
- Sub-module mips_wb_slot: one holding slot (full/reg/data, load/clear, ready), instantiated twice.
- Top level holds the arbiter, age bit, output registers and mask logic.
- The top level instantiates alongside mips_registers, with outputs wired port-for-port.

## Test plan
- Single write, no contention: A writes reg 2 = 0xE001C000 → edge N+1 signal_reg_write=1, write_reg=2; pending_regs[2] set from N until the write edge.
- Both accept on the same edge, A reg 3 = 0x11, B reg 4 = 0x22 → issue order A then B on consecutive cycles. b_ready=0 for one cycle.
- Same-destination ordering: B loads reg 5 = 0xAA, one cycle later A loads reg 5 = 0xBB while B is still full → B issued first, then A. A readback of reg 5 returns 0xBB.
- Register 0: A writes reg 0 = 0xFFFFFFFF → a_ready handshake completes, signal_reg_write stays 0, pending_regs stays 0.
- Streaming: both requesters hold valid for 20 cycles → exactly 20 issues, 10 each alternating, no beat lost or duplicated (compare against a scoreboard).
- Async reset asserted while both slots are full and signal_reg_write=1 → all outputs go to their reset values without a clock edge. After release, the first new request issues normally.
